// File: rtl/sobel_edge.sv
// Sobel edge stage: 3x3 window from two line buffers, |Gx|+|Gy| against a per-frame threshold, 3-clk latency.
// Optional build macro SOBEL_MAG_OUT_EN: output the saturated magnitude instead of the 0/255 edge map.
module sobel_edge #(
  parameter int IMG_W = 640
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       din_sop,
  input  logic       din_eop,
  input  logic       din_vld,
  input  logic [7:0] din,
  input  logic [7:0] thresh,
  output logic       dout_sop,
  output logic       dout_eop,
  output logic       dout_vld,
  output logic [7:0] dout
);

  // Stream framing: a beat exists only when din_vld is high; din_sop/din_eop are
  // meaningful only on such beats. There is no back-pressure, and dout_vld marks
  // each output beat exactly 3 clk after its input beat.

  localparam int CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);

  logic [CW-1:0] col_q;
  logic [CW-1:0] cur_col;
  logic [1:0]    row_q;
  logic [1:0]    cur_row;
  logic          frame_act;
  logic [7:0]    thr_q;

  logic [7:0]    lb0 [IMG_W];
  logic [7:0]    lb1 [IMG_W];
  logic [7:0]    lb0_rd;
  logic [7:0]    lb1_rd;

  logic [7:0]    win    [3][3];
  logic [7:0]    win_nx [3][3];

  logic [9:0]    gx_pos;
  logic [9:0]    gx_neg;
  logic [9:0]    gy_pos;
  logic [9:0]    gy_neg;
  logic signed [10:0] gx;
  logic signed [10:0] gy;
  logic          msk_in;

  logic [2:0]    sop_sr;
  logic [2:0]    eop_sr;
  logic [2:0]    vld_sr;

  logic signed [10:0] gx_q;
  logic signed [10:0] gy_q;
  logic          msk1;
  logic [10:0]   ax;
  logic [10:0]   ay;
  logic [10:0]   mag;
  logic [7:0]    res;
  logic [7:0]    res2;
  logic          msk2;

  // The sop beat itself is column 0 / row 0, so position is resolved before the counters update.
  always_comb begin
    cur_col = din_sop ? '0 : col_q;
    cur_row = din_sop ? 2'd0 : row_q;
  end

  assign lb0_rd = lb0[cur_col];
  assign lb1_rd = lb1[cur_col];

  // Line buffers are plain storage; read above happens before this write lands.
  always_ff @(posedge clk) begin
    if (din_vld) begin
      lb0[cur_col] <= din;
      lb1[cur_col] <= lb0_rd;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      col_q     <= '0;
      row_q     <= 2'd0;
      frame_act <= 1'b0;
      thr_q     <= 8'd0;
    end else if (din_vld) begin
      if (cur_col == COL_LAST) begin
        col_q <= '0;
        row_q <= (cur_row == 2'd2) ? 2'd2 : cur_row + 2'd1;
      end else begin
        col_q <= cur_col + CW'(1);
        row_q <= cur_row;
      end
      if (din_sop) begin
        frame_act <= 1'b1;
        thr_q     <= thresh;
      end
    end
  end

  // Window as it will look after this beat shifts in; Gx/Gy are taken from it directly.
  always_comb begin
    for (int r = 0; r < 3; r++) begin
      win_nx[r][0] = win[r][1];
      win_nx[r][1] = win[r][2];
    end
    win_nx[0][2] = lb1_rd;
    win_nx[1][2] = lb0_rd;
    win_nx[2][2] = din;

    gx_pos = {2'b00, win_nx[0][2]} + {1'b0, win_nx[1][2], 1'b0} + {2'b00, win_nx[2][2]};
    gx_neg = {2'b00, win_nx[0][0]} + {1'b0, win_nx[1][0], 1'b0} + {2'b00, win_nx[2][0]};
    gy_pos = {2'b00, win_nx[2][0]} + {1'b0, win_nx[2][1], 1'b0} + {2'b00, win_nx[2][2]};
    gy_neg = {2'b00, win_nx[0][0]} + {1'b0, win_nx[0][1], 1'b0} + {2'b00, win_nx[0][2]};
    gx     = $signed({1'b0, gx_pos}) - $signed({1'b0, gx_neg});
    gy     = $signed({1'b0, gy_pos}) - $signed({1'b0, gy_neg});

    msk_in = !(frame_act || din_sop) || (cur_row < 2'd2) || (cur_col < CW'(2));
  end

  // Framing delay is free-running so gaps propagate exactly like beats.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sop_sr <= 3'b000;
      eop_sr <= 3'b000;
      vld_sr <= 3'b000;
    end else begin
      sop_sr <= {sop_sr[1:0], din_sop & din_vld};
      eop_sr <= {eop_sr[1:0], din_eop & din_vld};
      vld_sr <= {vld_sr[1:0], din_vld};
    end
  end

  // Stage 1: window and gradients.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int r = 0; r < 3; r++) begin
        for (int c = 0; c < 3; c++) begin
          win[r][c] <= 8'd0;
        end
      end
      gx_q <= '0;
      gy_q <= '0;
      msk1 <= 1'b0;
    end else if (din_vld) begin
      win  <= win_nx;
      gx_q <= gx;
      gy_q <= gy;
      msk1 <= msk_in;
    end
  end

  always_comb begin
    ax  = gx_q[10] ? 11'(-gx_q) : 11'(gx_q);
    ay  = gy_q[10] ? 11'(-gy_q) : 11'(gy_q);
    mag = ax + ay;
`ifdef SOBEL_MAG_OUT_EN
    res = (mag > 11'd255) ? 8'hFF : mag[7:0];
`else
    res = (mag >= {3'b000, thr_q}) ? 8'hFF : 8'h00;
`endif
  end

  // Stage 2: magnitude and decision.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      res2 <= 8'd0;
      msk2 <= 1'b0;
    end else if (vld_sr[0]) begin
      res2 <= res;
      msk2 <= msk1;
    end
  end

  // Stage 3: output register with border mask applied.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dout <= 8'd0;
    end else if (vld_sr[1]) begin
      dout <= msk2 ? 8'd0 : res2;
    end
  end

  assign dout_sop = sop_sr[2];
  assign dout_eop = eop_sr[2];
  assign dout_vld = vld_sr[2];

endmodule

// File: tb/tb_sobel_edge.sv
// Randomized scoreboard bench for sobel_edge at IMG_W=16 against a frame-history Sobel model.
module tb_sobel_edge;

  localparam int W = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       din_sop = 1'b0;
  logic       din_eop = 1'b0;
  logic       din_vld = 1'b0;
  logic [7:0] din = 8'd0;
  logic [7:0] thresh = 8'd0;
  logic       dout_sop;
  logic       dout_eop;
  logic       dout_vld;
  logic [7:0] dout;

  sobel_edge #(.IMG_W(W)) dut (
    .clk      (clk),
    .rst      (rst),
    .din_sop  (din_sop),
    .din_eop  (din_eop),
    .din_vld  (din_vld),
    .din      (din),
    .thresh   (thresh),
    .dout_sop (dout_sop),
    .dout_eop (dout_eop),
    .dout_vld (dout_vld),
    .dout     (dout)
  );

  // clock / reset
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;
  int vld_cnt = 0;
  int ones_cnt = 0;

  // expected entry: {output cycle stamp, sop, eop, dout}
  logic [41:0] exp_q[$];

  // reference model: all pixels since the last sop, indexed by beat number
  logic [7:0] hist[$];
  logic       act_m = 1'b0;
  logic [7:0] thr_m = 8'd0;

  function automatic logic [7:0] ref_out();
    int n;
    int gx;
    int gy;
    int mag;
    int p[3][3];
    n = hist.size() - 1;
    if (!act_m || (n / W) < 2 || (n % W) < 2) return 8'd0;
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 3; c++)
        p[r][c] = int'(hist[n - (2 - r) * W - (2 - c)]);
    gx = (p[0][2] + 2 * p[1][2] + p[2][2]) - (p[0][0] + 2 * p[1][0] + p[2][0]);
    gy = (p[2][0] + 2 * p[2][1] + p[2][2]) - (p[0][0] + 2 * p[0][1] + p[0][2]);
    mag = (gx < 0 ? -gx : gx) + (gy < 0 ? -gy : gy);
`ifdef SOBEL_MAG_OUT_EN
    return (mag > 255) ? 8'd255 : 8'(mag);
`else
    return (mag >= int'(thr_m)) ? 8'd255 : 8'd0;
`endif
  endfunction

  task automatic check_val(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // driver tasks
  task automatic drive(input logic sop, input logic eop, input logic [7:0] pix, input logic [7:0] thr);
    @(posedge clk);
    #1;
    din_sop = sop;
    din_eop = eop;
    din     = pix;
    thresh  = thr;
    din_vld = 1'b1;
    if (sop) begin
      hist.delete();
      act_m = 1'b1;
      thr_m = thr;
    end
    hist.push_back(pix);
    exp_q.push_back({32'(cyc + 3), sop, eop, ref_out()});
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      din_vld = 1'b0;
      din_sop = 1'b0;
      din_eop = 1'b0;
      din     = 8'($urandom);
      thresh  = 8'($urandom);
    end
  endtask

  // kind: 0 flat, 1 vertical step, 2 horizontal step, 3 random
  task automatic send_frame(input int kind, input int lvl, input int thr, input bit stall);
    logic [7:0] pix;
    for (int r = 0; r < 8; r++) begin
      for (int c = 0; c < W; c++) begin
        case (kind)
          0:       pix = 8'd128;
          1:       pix = (c < 8) ? 8'd0 : 8'(lvl);
          2:       pix = (r < 4) ? 8'd0 : 8'(lvl);
          default: pix = 8'($urandom);
        endcase
        if (stall && !(r == 0 && c == 0) && $urandom_range(0, 1) == 1)
          idle($urandom_range(1, 2));
        drive(r == 0 && c == 0, r == 7 && c == W - 1, pix, 8'(thr));
      end
    end
    idle(5);
  endtask

  task automatic send_partial(input int n);
    for (int i = 0; i < n; i++) drive(i == 0, 1'b0, 8'($urandom), 8'($urandom));
  endtask

  // scoreboard monitor
  always @(negedge clk) begin
    logic [41:0] e;
    if (!rst) begin
      if (dout_vld) begin
        vld_cnt++;
        if (dout == 8'd255) ones_cnt++;
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_out: cycle %0d dout %0d with no expected beat", cyc, dout);
        end else begin
          e = exp_q.pop_front();
          if ({32'(cyc), dout_sop, dout_eop, dout} !== e) begin
            errors++;
            $display("FAIL out_beat: got cyc %0d sop %0b eop %0b dout %0d expected cyc %0d sop %0b eop %0b dout %0d",
                     cyc, dout_sop, dout_eop, dout, e[41:10], e[9], e[8], e[7:0]);
          end
        end
      end else begin
        checks++;
        if (dout_sop || dout_eop) begin
          errors++;
          $display("FAIL idle_framing: got sop %0b eop %0b expected 0 0", dout_sop, dout_eop);
        end
        if (exp_q.size() > 0 && exp_q[0][41:10] <= 32'(cyc)) begin
          e = exp_q.pop_front();
          errors++;
          $display("FAIL missing_out: got no dout_vld at cycle %0d expected beat due at %0d", cyc, e[41:10]);
        end
      end
    end
  end

  initial begin
    #1 rst = 1'b1;
    #1;
    check_val("reset_dout", int'(dout), 0);
    check_val("reset_vld", int'(dout_vld), 0);
    check_val("reset_sop", int'(dout_sop), 0);
    check_val("reset_eop", int'(dout_eop), 0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    idle(2);

    vld_cnt = 0;
    send_frame(0, 128, 10, 1'b0);
    check_val("flat_vld_count", vld_cnt, 128);

    ones_cnt = 0;
    send_frame(1, 200, 100, 1'b0);
`ifndef SOBEL_MAG_OUT_EN
    check_val("vstep_edges", ones_cnt, 12);
`endif

    ones_cnt = 0;
    send_frame(2, 50, 150, 1'b0);
`ifndef SOBEL_MAG_OUT_EN
    check_val("hstep_edges", ones_cnt, 28);
`endif

    ones_cnt = 0;
    send_frame(2, 50, 201, 1'b0);
    check_val("hstep_high_thr", ones_cnt, 0);

    ones_cnt = 0;
    send_frame(1, 200, 100, 1'b1);
`ifndef SOBEL_MAG_OUT_EN
    check_val("vstep_stall_edges", ones_cnt, 12);
`endif

    send_frame(3, 0, $urandom_range(0, 255), 1'b1);
    send_frame(3, 0, $urandom_range(100, 600), 1'b1);

    drive(1'b1, 1'b1, 8'($urandom), 8'd0);
    idle(5);

    send_partial(24);
    send_frame(3, 0, $urandom_range(0, 400), 1'b0);

    // reset in the middle of a frame
    send_partial(40);
    @(posedge clk);
    #1;
    rst     = 1'b1;
    din_vld = 1'b0;
    din_sop = 1'b0;
    din_eop = 1'b0;
    exp_q.delete();
    hist.delete();
    act_m = 1'b0;
    #1;
    check_val("midrst_dout", int'(dout), 0);
    check_val("midrst_vld", int'(dout_vld), 0);
    check_val("midrst_sop", int'(dout_sop), 0);
    repeat (5) @(posedge clk);
    #1 rst = 1'b0;
    for (int i = 0; i < 20; i++) drive(1'b0, 1'b0, 8'($urandom), 8'd0);
    idle(3);
    ones_cnt = 0;
    send_frame(1, 200, 100, 1'b0);
`ifndef SOBEL_MAG_OUT_EN
    check_val("post_rst_vstep_edges", ones_cnt, 12);
`endif

    idle(10);
    check_val("queue_drained", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
